uart_rx: RTL
============

# uart_rx

Serial receiver for the 8N1 link used by the board's UART transmitter, running in the `clk100` domain. It synchronises the asynchronous `rx_pin`, recovers bytes by mid-bit sampling, flags framing errors and buffers received bytes in a small first-word-fall-through FIFO. The meter control FSM pops this FIFO to accept host commands.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 868: `clk` cycles per bit (100 MHz / 115200). Legal values are ≥ 4.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.

Ports:

- `clk`, in, 1: system clock (`clk100`).
- `rst`, in, 1: reset. One clock; reset is synchronous and active-low.
- `rx_pin`, in, 1: asynchronous serial input, idle high.
- `rx_byte`, out, 8: FIFO head. Valid only while `rx_ready`=1.
- `rx_ready`, out, 1: FIFO non-empty.
- `rx_rd`, in, 1: pop request. Honoured only when `rx_ready`=1.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`, out, 1: one-cycle pulse on parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped because the FIFO is full.

## Operation

- **Input synchroniser:** two flops, reset value 1. All logic uses the synchronised `rxs`.
- **Bit counter:** `cnt`, width clog2(CLKS_PER_BIT). **Bit index:** 3 bits. **Shift register:** LSB first.
- **FSM states:** IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_HIGH.
- **IDLE:** on `rxs`=0, load `cnt`=0 and go to START.
- **START:** at `cnt`=CLKS_PER_BIT/2−1, resample.
  - `rxs`=0: go to DATA, `cnt`=0, bit index 0.
  - `rxs`=1: glitch; return to IDLE with no flag.
- **DATA:** at `cnt`=CLKS_PER_BIT−1, shift in `rxs` and reset `cnt`. After bit index 7, go to PARITY or STOP.
- **PARITY:** sample after CLKS_PER_BIT. On mismatch, pulse `parity_err` and discard the byte, but still proceed to STOP.
- **STOP:** sample after CLKS_PER_BIT.
  - `rxs`=1: push the byte (unless discarded) and go to IDLE.
  - `rxs`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then go to IDLE. A held-low line (break) yields exactly one `frame_err`.
- **FIFO:**
  - Pointers are clog2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the MSB.
  - `rx_byte` = mem[rd_ptr].
- **Push and pop cases:**
  - Push when full with no pop: byte dropped, `overrun` pulses, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both occur, no `overrun`.
  - Push and pop in the same cycle when empty: push only; pop ignored.
  - `rx_rd` while empty: ignored.

## Timing

- **Reset values:**
  - `rx_ready`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `rx_byte`=don't-care.
  - FSM in IDLE, pointers 0, synchroniser 1.
- **Reset mid-frame:** asserting `rst` low mid-frame aborts the frame. No flags pulse. The partially received frame is not pushed.
- **Start detection:** a falling edge on `rx_pin` reaches `rxs` 2 cycles later. The FSM leaves IDLE in the following cycle.
- **Sample points** (t0 = START entry):
  - start resample: t0+CLKS_PER_BIT/2−1
  - data bit k: t0+CLKS_PER_BIT/2−1+(k+1)·CLKS_PER_BIT
  - stop bit: the next bit slot after bit 7 (after parity when enabled)
- **Push latency:** the push happens in the stop-sample cycle. `rx_ready` rises and `rx_byte` is valid the following cycle.
- **Error flags:** `frame_err` and `parity_err` pulse in the sample cycle. `overrun` pulses in the push cycle.
- **Pop:** `rx_rd` with `rx_ready`=1 advances the head. The new `rx_byte` (or `rx_ready`=0) appears the next cycle.
- **Back-to-back frames:** IDLE is re-entered at the stop sample, which is half a bit before the nominal frame end. A start bit that follows immediately is therefore caught.

## Configuration

- **`UART_RX_PARITY_EN` defined:** frame is 8E1. The PARITY state is compiled in. The expected parity bit is the XOR of the 8 data bits. A mismatch pulses `parity_err` and the byte is discarded.
- **`UART_RX_PARITY_EN` undefined:** frame is 8N1. No PARITY state. `parity_err` is constant 0.

## Test plan

All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4, macro off unless stated.

1. **Single byte:** send 0xA5 → `rx_ready` rises 1 cycle after the stop sample with `rx_byte`=0xA5. Pulse `rx_rd` → `rx_ready`=0 next cycle. No flags.
2. **Glitch rejection:** drive `rx_pin` low for 4 cycles then high → no push, no flags, FSM back in IDLE.
3. **Framing error and break:** send 0x3C with stop bit 0, then hold low for 40 bit times, then send 0x55 → exactly one `frame_err`, FIFO holds only 0x55.
4. **Overrun:** send 5 bytes 0x01–0x05 without `rx_rd` → one `overrun` pulse on the 5th byte. Pops return 0x01–0x04, then `rx_ready`=0.
5. **Full FIFO push/pop and mid-frame reset:**
   - With the FIFO full, assert `rx_rd` in the stop-sample cycle of byte 0x66 → no `overrun`. Contents afterwards are 0x02, 0x03, 0x04, 0x66.
   - Then drive `rst` low mid-frame → all outputs at reset values, no push.
6. **Parity (macro on):** send 0x07 with parity bit 1 → pushed. Send 0x07 with parity bit 0 → `parity_err` pulse, no push.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, framing/overrun flags
// and a small first-word-fall-through byte FIFO.
// Optional 8E1 mode with a parity check when UART_RX_PARITY_EN is defined.
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   rx_pin     asynchronous serial input, idle high
//   rx_byte    FIFO head, valid while rx_ready is 1
//   rx_ready   FIFO non-empty
//   rx_rd      pop request, ignored while the FIFO is empty
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   parity_err one-cycle pulse on parity mismatch (0 without the macro)
//   overrun    one-cycle pulse when a completed byte is dropped on a full FIFO
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    input  logic       rx_rd,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t          state, state_n;
    logic            sync1, rxs;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bidx, bidx_n;
    logic [7:0]      shreg, shreg_n;
    logic            bad, bad_n;
    logic            push, fe;
`ifdef UART_RX_PARITY_EN
    logic            pe;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, push_g, do_pop, do_wr;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bidx_n  = bidx;
        shreg_n = shreg;
        bad_n   = bad;
        push    = 1'b0;
        fe      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                    bad_n   = 1'b0;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bidx_n  = '0;
                    // a start bit that is high again at mid-bit is a glitch
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    bidx_n  = bidx + 3'd1;
                    if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    if (rxs != ^shreg) begin
                        pe    = 1'b1;
                        bad_n = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        // back to IDLE half a bit early so a
                        // directly following start bit is caught
                        push    = !bad;
                        state_n = IDLE;
                    end else begin
                        fe      = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // a held-low line (break) reports only one frame_err
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            bad   <= 1'b0;
        end else begin
            sync1 <= rx_pin;
            rxs   <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
            bad   <= bad_n;
        end
    end

    // pointer MSB tells full from empty when the index bits match
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_g = push & rst;
    assign do_pop = rx_rd & ~empty & rst;
    assign do_wr  = push_g & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign rx_byte   = mem[rd_ptr[AW-1:0]];
    assign rx_ready  = ~empty;
    assign frame_err = fe & rst;
    assign overrun   = push_g & full & ~do_pop;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe & rst;
`else
    assign parity_err = 1'b0;
`endif

endmodule
